// File: rtl/queue_push_arbiter.sv
// ----------------------------------------------------------------------------
// queue_push_arbiter
//
// Arbitrates four requesters onto the push side of one downstream queue.
// Arbitration is round-robin and tenure-based. An idle arbiter picks the first
// requester at or after rrPtr, and that requester then owns the queue for up
// to MAX_BURST pushes. A full queue stalls the owner but does not take
// ownership away. When the owner drops its request, ownership is released.
// When a tenure ends, one idle cycle follows before the next owner is granted.
//
// Optional feature (macro QUEUE_PUSH_ARBITER_STATS_EN):
//   defined   -> saturating per-requester grant counters and an owner-stall
//                counter are built.
//   undefined -> grantCount_OUT and stallCount_OUT are tied to zero.
//
// Parameters:
//   DATA_WIDTH : width of one queue entry
//   MAX_BURST  : maximum consecutive grants per tenure (1..255)
//
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   req_IN         : per-requester push request (bit i = requester i)
//   data_IN        : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   fullFlag_IN    : downstream queue full
//   grant_OUT      : one-hot-or-zero grant, combinational
//   pushReq_OUT    : push strobe to the queue (= |grant_OUT)
//   data_OUT       : granted data, zero when no push
//   grantCount_OUT : per-requester grant counters, 16 bits each
//   stallCount_OUT : cycles in which the owner requested while the queue was full
// ----------------------------------------------------------------------------
module queue_push_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req_IN,
  input  logic [4*DATA_WIDTH-1:0] data_IN,
  input  logic                    fullFlag_IN,
  output logic [3:0]              grant_OUT,
  output logic                    pushReq_OUT,
  output logic [DATA_WIDTH-1:0]   data_OUT,
  output logic [4*16-1:0]         grantCount_OUT,
  output logic [15:0]             stallCount_OUT
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  // Value of burstCnt when the final grant of a tenure is issued.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  logic [0:0] state;
  logic [1:0] owner;
  logic [1:0] rrPtr;
  logic [7:0] burstCnt;

  logic [1:0] pickIdx;
  logic       ownerReq;
  logic       granted;
  logic       stalled;

  // Round-robin search: the first set request at rrPtr, rrPtr+1, ... (mod 4).
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first;
    // otherwise a path that leaves it unassigned infers a latch.
    pickIdx = rrPtr;
    for (int k = 3; k >= 0; k--) begin
      if (req_IN[rrPtr + 2'(k)]) pickIdx = rrPtr + 2'(k);
    end
  end

  assign ownerReq = req_IN[owner];
  assign granted  = (state == OWN) && ownerReq && !fullFlag_IN;
  assign stalled  = (state == OWN) && ownerReq && fullFlag_IN;

  always_comb begin
    grant_OUT = '0;
    if (granted) grant_OUT[owner] = 1'b1;
  end

  assign pushReq_OUT = granted;

  always_comb begin
    data_OUT = '0;
    if (granted) data_OUT = data_IN[owner*DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitration state.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // register samples pre-edge values, regardless of statement order.
    if (!reset) begin
      state    <= IDLE;
      owner    <= 2'd0;
      rrPtr    <= 2'd0;
      burstCnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if ((|req_IN) && !fullFlag_IN) begin
            state    <= OWN;
            owner    <= pickIdx;
            burstCnt <= 8'd0;
          end
        end
        OWN: begin
          if (!ownerReq) begin
            // Owner has nothing left to push: release without a grant.
            state <= IDLE;
            rrPtr <= owner + 2'd1;
          end else if (granted) begin
            burstCnt <= burstCnt + 8'd1;
            if (burstCnt == LAST_BEAT) begin
              state <= IDLE;
              rrPtr <= owner + 2'd1;
            end
          end
          // If the owner requests but the queue is full, everything is held.
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUEUE_PUSH_ARBITER_STATS_EN
  logic [15:0] grantCnt [4];
  logic [15:0] stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) grantCnt[i] <= 16'd0;
      stallCnt <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (grant_OUT[i] && grantCnt[i] != 16'hFFFF) grantCnt[i] <= grantCnt[i] + 16'd1;
      end
      if (stalled && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
    end
  end

  always_comb begin
    grantCount_OUT = '0;
    for (int i = 0; i < 4; i++) grantCount_OUT[i*16 +: 16] = grantCnt[i];
  end

  assign stallCount_OUT = stallCnt;
`else
  assign grantCount_OUT = '0;
  assign stallCount_OUT = 16'd0;

  // The stall term only feeds the counters.
  logic unusedStall;
  assign unusedStall = stalled;
`endif

endmodule

// File: tb/tb_queue_push_arbiter.sv
// ----------------------------------------------------------------------------
// tb_queue_push_arbiter
//
// Scoreboard bench for queue_push_arbiter (DATA_WIDTH=8, MAX_BURST=4).
// A tenure-level reference model predicts each push: its cycle, the requester
// and the data. Predictions go into a queue. An independent negedge monitor
// pops the queue and compares whenever the DUT pushes. The monitor also flags
// a predicted push that did not happen in the predicted cycle.
// ----------------------------------------------------------------------------
module tb_queue_push_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    req_IN = '0;
  logic [4*DW-1:0] data_IN = '0;
  logic          fullFlag_IN = 1'b0;
  logic [3:0]    grant_OUT;
  logic          pushReq_OUT;
  logic [DW-1:0] data_OUT;
  logic [63:0]   grantCount_OUT;
  logic [15:0]   stallCount_OUT;

  queue_push_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_IN         (req_IN),
    .data_IN        (data_IN),
    .fullFlag_IN    (fullFlag_IN),
    .grant_OUT      (grant_OUT),
    .pushReq_OUT    (pushReq_OUT),
    .data_OUT       (data_OUT),
    .grantCount_OUT (grantCount_OUT),
    .stallCount_OUT (stallCount_OUT)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int            cyc;
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference model, kept in tenure terms: the current owner (-1 = none), the
  // grants remaining in this tenure, and where the next search starts.
  int mOwner = -1;
  int mLeft  = 0;
  int mStart = 0;
  int mGrants[4] = '{0, 0, 0, 0};
  int mStall = 0;

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_step(output int g);
    g = -1;
    if (mOwner < 0) begin
      if (req_IN != 4'b0 && !fullFlag_IN) begin
        for (int k = 0; k < 4; k++) begin
          if (mOwner < 0 && req_IN[(mStart + k) % 4]) mOwner = (mStart + k) % 4;
        end
        mLeft = MB;
      end
    end else if (!req_IN[mOwner]) begin
      mStart = (mOwner + 1) % 4;
      mOwner = -1;
    end else if (fullFlag_IN) begin
      if (mStall < 65535) mStall++;
    end else begin
      g = mOwner;
      expQ.push_back('{cycle, mOwner, data_IN[mOwner*DW +: DW]});
      if (mGrants[mOwner] < 65535) mGrants[mOwner]++;
      mLeft--;
      if (mLeft == 0) begin
        mStart = (mOwner + 1) % 4;
        mOwner = -1;
      end
    end
  endtask

  // Apply inputs for one cycle (called at posedge+1) and step the model.
  task automatic drive(input logic [3:0] r, input logic [4*DW-1:0] d, input logic f, output int g);
    req_IN      = r;
    data_IN     = d;
    fullFlag_IN = f;
    model_step(g);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input int n, input logic [3:0] r, input logic [4*DW-1:0] d, input logic f);
    int g;
    for (int i = 0; i < n; i++) drive(r, d, f, g);
  endtask

  // Assert reset in the middle of a cycle, then check that the outputs clear
  // immediately, without waiting for a clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_grant", 64'(grant_OUT), 64'd0);
    check("rst_push", 64'(pushReq_OUT), 64'd0);
    check("rst_data", 64'(data_OUT), 64'd0);
    check("rst_gcnt", grantCount_OUT, 64'd0);
    check("rst_scnt", 64'(stallCount_OUT), 64'd0);
    req_IN = '0;
    fullFlag_IN = 1'b0;
    expQ.delete();
    mOwner = -1;
    mLeft  = 0;
    mStart = 0;
    mStall = 0;
    for (int i = 0; i < 4; i++) mGrants[i] = 0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("push_is_or_grant", 64'(pushReq_OUT), 64'(|grant_OUT));
      if (pushReq_OUT) begin
        check("no_push_when_full", 64'(fullFlag_IN), 64'd0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_push: got grant %b, required no push (cycle %0d)", grant_OUT, cycle);
        end else begin
          e = expQ.pop_front();
          check("push_cycle", 64'(cycle), 64'(e.cyc));
          check("grant_onehot", 64'(grant_OUT), 64'(4'b0001 << e.id));
          check("push_data", 64'(data_OUT), 64'(e.data));
        end
      end else begin
        check("data_zero_no_push", 64'(data_OUT), 64'd0);
        if (expQ.size() > 0 && expQ[0].cyc == cycle) begin
          e = expQ.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_push: got no push, required grant to %0d (cycle %0d)", e.id, cycle);
        end
      end
    end
  end

  localparam logic [4*DW-1:0] DATA_DIR = {8'hD3, 8'hC2, 8'hB1, 8'hA1};

  logic [3:0]    pending;
  logic [DW-1:0] pdata [4];
  logic [4*DW-1:0] dvec;
  logic [15:0]   stallBefore;
  int            g;

  initial begin
    // Reset held from time 0.
    #1;
    check("por_grant", 64'(grant_OUT), 64'd0);
    check("por_push", 64'(pushReq_OUT), 64'd0);
    check("por_data", 64'(data_OUT), 64'd0);
    check("por_gcnt", grantCount_OUT, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // A single steady requester: 4 grants, one bubble cycle, then grants again.
    drive_n(8, 4'b0001, DATA_DIR, 1'b0);
    drive_n(2, 4'b0000, DATA_DIR, 1'b0);

    // Reset in the middle of requester 3's tenure, then all four request.
    drive_n(3, 4'b1000, DATA_DIR, 1'b0);
    do_reset();
    drive_n(26, 4'b1111, DATA_DIR, 1'b0);   // order 0,1,2,3,0
    drive_n(2, 4'b0000, DATA_DIR, 1'b0);

    // Owner 1 drops its request after one grant; requester 3 is next.
    do_reset();
    drive_n(2, 4'b1010, DATA_DIR, 1'b0);
    drive_n(3, 4'b1000, DATA_DIR, 1'b0);
    drive_n(2, 4'b0000, DATA_DIR, 1'b0);

    // Owner 2 stalls for 3 cycles after 2 grants, then gets 2 more grants.
    stallBefore = stallCount_OUT;
    drive_n(3, 4'b0100, DATA_DIR, 1'b0);
    drive_n(3, 4'b0100, DATA_DIR, 1'b1);
    drive_n(3, 4'b0100, DATA_DIR, 1'b0);
    drive_n(1, 4'b0000, DATA_DIR, 1'b0);
`ifdef QUEUE_PUSH_ARBITER_STATS_EN
    check("stall_delta", 64'(stallCount_OUT - stallBefore), 64'd3);
`else
    check("stall_tied_zero", 64'(stallCount_OUT), 64'd0);
`endif

    // Idle with the queue full: nothing happens until full deasserts.
    drive_n(3, 4'b0100, DATA_DIR, 1'b1);
    drive_n(3, 4'b0100, DATA_DIR, 1'b0);
    drive_n(2, 4'b0000, DATA_DIR, 1'b0);

    // Randomized traffic. Each requester holds its request and data until it
    // is granted, then it may present a new item or go quiet.
    pending = '0;
    for (int i = 0; i < 4; i++) pdata[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        pending = '0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          pdata[i]   = DW'($urandom);
        end
        dvec[i*DW +: DW] = pdata[i];
      end
      drive(pending, dvec, ($urandom_range(0, 4) == 0), g);
      if (g >= 0) begin
        pending[g] = ($urandom_range(0, 1) == 1);
        pdata[g]   = DW'($urandom);
      end
    end
    drive_n(3, 4'b0000, '0, 1'b0);

    check("scoreboard_drained", 64'(expQ.size()), 64'd0);
`ifdef QUEUE_PUSH_ARBITER_STATS_EN
    for (int i = 0; i < 4; i++) check("grant_count", 64'(grantCount_OUT[i*16 +: 16]), 64'(mGrants[i]));
    check("stall_count", 64'(stallCount_OUT), 64'(mStall));
`else
    check("gcnt_tied_zero", grantCount_OUT, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
